// File: rtl/ste_chain_pkg.sv
// Shared types and constants for the STE chain matcher.
package ste_chain_pkg;

  // How stage 0 of the chain is enabled.
  typedef enum logic [0:0] {
    START_ALL_INPUT = 1'b0,  // stage 0 may start a match on every symbol
    START_OF_DATA   = 1'b1   // only the first symbol after reset/flush may start a match
  } start_mode_e;

  // Start-of-data tracking states.
  typedef enum logic [0:0] {
    SOD_ARMED = 1'b0,        // next consumed symbol is the first of the stream
    SOD_SPENT = 1'b1         // the first symbol has already been consumed
  } sod_state_e;

  // ASCII letter ranges and the bit that distinguishes upper and lower case.
  localparam logic [7:0] ASCII_UPPER_A  = 8'h41;
  localparam logic [7:0] ASCII_UPPER_Z  = 8'h5A;
  localparam logic [7:0] ASCII_LOWER_A  = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z  = 8'h7A;
  localparam int         ASCII_CASE_BIT = 5;

endpackage

// File: rtl/ste_chain_matcher_if.sv
// Stream, programming and report signals of the STE chain matcher.
interface ste_chain_matcher_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic             run;
  logic [WIDTH-1:0] symbols;
  logic             flush;
  logic             prog_we;
  logic [AW-1:0]    prog_addr;
  logic [WIDTH-1:0] prog_data;
  logic             prog_len_we;
  logic [LW-1:0]    prog_len;
  logic             prog_err;
  logic [DEPTH-1:0] active;
  logic             report;
  logic [CNT_W-1:0] report_pos;
  logic [CNT_W-1:0] report_cnt;

  // Driver side: feeds symbols and programs the pattern.
  modport master (
    output run, symbols, flush, prog_we, prog_addr, prog_data, prog_len_we, prog_len,
    input  prog_err, active, report, report_pos, report_cnt
  );

  // Matcher side.
  modport slave (
    input  run, symbols, flush, prog_we, prog_addr, prog_data, prog_len_we, prog_len,
    output prog_err, active, report, report_pos, report_cnt
  );
endinterface

// File: rtl/ste_symbol_cmp.sv
// Single-stage symbol comparator for the STE chain.
// Optional feature macro: CASE_FOLD_EN (ASCII letters compare case-insensitively).
module ste_symbol_cmp
  import ste_chain_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] sym,
  input  logic [WIDTH-1:0] pat,
  output logic             hit
);

`ifdef CASE_FOLD_EN
  // Letters lose their case bit; every other code point stays exact.
  function automatic logic [WIDTH-1:0] fold(input logic [WIDTH-1:0] x);
    logic             letter;
    logic [WIDTH-1:0] y;
    letter = ((x >= WIDTH'(ASCII_UPPER_A)) && (x <= WIDTH'(ASCII_UPPER_Z))) ||
             ((x >= WIDTH'(ASCII_LOWER_A)) && (x <= WIDTH'(ASCII_LOWER_Z)));
    y = x;
    if (letter) y[ASCII_CASE_BIT] = 1'b0;
    return y;
  endfunction

  assign hit = (fold(sym) == fold(pat));
`else
  assign hit = (sym == pat);
`endif

endmodule

// File: rtl/ste_chain_matcher.sv
// Linear STE chain matcher: one stage per pattern symbol, reports each
// completed occurrence with its stream offset and a saturating count.
// Optional feature macro: CASE_FOLD_EN (passed down to ste_symbol_cmp).
module ste_chain_matcher
  import ste_chain_pkg::*;
#(
  parameter int          WIDTH      = 8,
  parameter int          DEPTH      = 8,
  parameter start_mode_e START_MODE = START_ALL_INPUT,
  parameter int          CNT_W      = 32
) (
  input logic                clk,
  input logic                reset,
  ste_chain_matcher_if.slave bus
);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] pattern_reg [DEPTH];
  logic [LW-1:0]    len_reg;
  logic [DEPTH-1:0] active_reg;
  logic [DEPTH-1:0] active_next;
  logic [DEPTH-1:0] hit;
  logic [DEPTH-1:0] in_len;
  logic [DEPTH-1:0] last_mask;
  logic [CNT_W-1:0] pos_reg;
  logic [CNT_W-1:0] report_pos_reg;
  logic [CNT_W-1:0] report_cnt_reg;
  logic             report_reg;
  logic             prog_err_reg;
  sod_state_e       state_reg;
  sod_state_e       state_next;
  logic             start_en;
  logic             len_bad;
  logic             len_ok;
  logic             prog_blocked;
  logic             complete;

  // Programming is only legal while the stream is idle; oversize lengths are rejected.
  assign len_bad      = bus.prog_len_we && (bus.prog_len > LW'(DEPTH));
  assign len_ok       = bus.prog_len_we && !bus.run && !len_bad;
  assign prog_blocked = bus.run && (bus.prog_we || bus.prog_len_we);

  assign start_en = (START_MODE == START_ALL_INPUT) || (state_reg == SOD_ARMED);

  // One comparator per stage; stages beyond the programmed length never activate.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      ste_symbol_cmp #(.WIDTH(WIDTH)) u_cmp (
        .sym (bus.symbols),
        .pat (pattern_reg[gi]),
        .hit (hit[gi])
      );
      assign in_len[gi]    = (LW'(gi) < len_reg);
      assign last_mask[gi] = (LW'(gi + 1) == len_reg);
      if (gi == 0) begin : g_head
        assign active_next[gi] = start_en & hit[gi] & in_len[gi];
      end else begin : g_body
        assign active_next[gi] = active_reg[gi-1] & hit[gi] & in_len[gi];
      end
    end
  endgenerate

  // A zero length gives an empty mask, so it can never complete.
  assign complete = |(active_next & last_mask);

  // Start-of-data state: flush rearms, any consumed symbol spends the start.
  always_comb begin
    state_next = state_reg;
    if (bus.flush)    state_next = SOD_ARMED;
    else if (bus.run) state_next = SOD_SPENT;
  end

  // Start-of-data state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= SOD_ARMED;
    else        state_reg <= state_next;
  end

  // Pattern symbols and active length.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) pattern_reg[i] <= '0;
      len_reg <= '0;
    end else begin
      if (bus.prog_we && !bus.run && (int'(bus.prog_addr) < DEPTH))
        pattern_reg[bus.prog_addr] <= bus.prog_data;
      if (len_ok) len_reg <= bus.prog_len;
    end
  end

  // Chain advance, position counter and report generation; flush beats run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_reg     <= '0;
      pos_reg        <= '0;
      report_reg     <= 1'b0;
      report_pos_reg <= '0;
      report_cnt_reg <= '0;
    end else begin
      report_reg <= 1'b0;
      if (bus.flush) begin
        active_reg <= '0;
        pos_reg    <= '0;
      end else if (bus.run) begin
        active_reg <= active_next;
        pos_reg    <= pos_reg + 1'b1;
        if (complete) begin
          report_reg     <= 1'b1;
          report_pos_reg <= pos_reg;
          if (report_cnt_reg != '1) report_cnt_reg <= report_cnt_reg + 1'b1;
        end
      end else if (len_ok) begin
        active_reg <= '0;
      end
    end
  end

  // Programming error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prog_err_reg <= 1'b0;
    else        prog_err_reg <= prog_blocked || len_bad;
  end

  assign bus.active     = active_reg;
  assign bus.report     = report_reg;
  assign bus.report_pos = report_pos_reg;
  assign bus.report_cnt = report_cnt_reg;
  assign bus.prog_err   = prog_err_reg;

endmodule
